drive_stage: RTL
================

Name: drive_stage

Overview:
- Output stage sitting directly downstream of the pattern buffer.
- Consumes its per-phase drive words (p_drive active-low, n_drive active-high) and the tweak words.
- Produces the final registered gate signals for the pad drivers: time-gated tweak lanes, shoot-through protection and break-before-make guarding.
- All outputs are registered, one clock after the inputs.

Parameters:
- buffer_width, 8, width of every drive and tweak word (one bit per output leg)
- cnt_width, 8, width of the phase-time counter; must be >= width of tweak_delay (8)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pwm  input  1  raw pwm, same signal fed to the pattern buffer
- en  input  1  global output enable; 0 forces safe state
- fault_clr  input  1  clears sticky fault (single-cycle pulse)
- p_drive  input  buffer_width  high-side drive word, bit=0 means leg on
- n_drive  input  buffer_width  low-side drive word, bit=1 means leg on
- tweak_delay  input  8  phase-relative switch time for tweak lanes, in clocks
- tweak_sense  input  8  per-lane gating sense, bit k for lane k
- tweak_drive_0..tweak_drive_7  input  buffer_width each  per-lane tweak leg masks
- p_out  output  buffer_width  guarded high-side gates (active-low)
- n_out  output  buffer_width  guarded low-side gates (active-high)
- tweak_out_0..tweak_out_7  output  buffer_width each  time-gated tweak gates
- fault  output  1  sticky: a p/n conflict was seen
- fault_cnt  output  8  saturating count of conflict cycles

Behaviour:
- Reset, and the cycle after reset:
  - p_out = all 1, n_out = 0, tweak_out_k = 0, fault = 0, fault_cnt = 0
  - phase_cnt = 0, pwm_prev = 0
- Edge detect: pwm_prev <= pwm every cycle. edge = (pwm != pwm_prev).
- Phase counter:
  - edge: phase_cnt <= 0
  - otherwise: phase_cnt <= phase_cnt+1, saturating at 2^cnt_width-1 (no wrap)
  - The counter runs regardless of en.
- Lane k active (combinational, from the current phase_cnt):
  - tweak_sense[k]=1: active when phase_cnt >= tweak_delay (late lane)
  - tweak_sense[k]=0: active when phase_cnt < tweak_delay (early lane)
  - Consequence: tweak_delay=0 with sense 0 is never active; with sense 1 it is always active.
- tweak_out_k <= (en && active_k) ? tweak_drive_k : 0.
- Conflict: conflict[i] = ~p_drive[i] & n_drive[i].
- Per-leg guard, evaluated against the registered outputs:
  - p_on_ok[i] = ~conflict[i] & ~n_out[i]
  - n_on_ok[i] = ~conflict[i] & p_out[i]
  - p_out[i] <= (en & p_on_ok[i]) ? p_drive[i] : 1
  - n_out[i] <= (en & n_on_ok[i]) ? n_drive[i] : 0
- The guard gives at least one all-off cycle on every p-on to n-on handover (and the reverse), even if the upstream deadtime is absent.
- fault:
  - set when any conflict bit is 1 and en=1
  - cleared by fault_clr
  - if fault_clr and a new conflict occur in the same cycle, set wins
- fault_cnt:
  - increments by 1 per cycle with any conflict (en=1), saturating at 255
  - cleared only by reset
- en=0:
  - all outputs take the safe state the next cycle
  - fault and fault_cnt hold
- Reset mid-phase: the counter restarts at 0. The first edge after reset is judged against pwm_prev=0.
- Latency: every output reflects the inputs sampled on the previous clock edge (1 cycle).

Decomposition:
- Shared package pat_drive_pkg:
  - constants DRIVE_WIDTH=8, NUM_TWEAK=8, DELAY_WIDTH=8
  - safe-state constants P_OFF (all 1) and N_OFF (all 0)
- One natural sub-module: drive_leg_guard. It is per-bit, instantiated buffer_width times, and implements the conflict and break-before-make logic for one leg.
- Tweak gating and the counter stay in the top level.

Test Plan:
- Reset, then en=1, pwm held 0, p_drive=8'hFF, n_drive=8'h0F -> 1 cycle later n_out=8'h0F, p_out=8'hFF, fault=0.
- pwm toggles 0->1 with tweak_delay=4, sense=8'h01, tweak_drive_0=8'hAA, tweak_drive_1=8'h55 ->
  - tweak_out_0=0 while phase_cnt 0..3, then 8'hAA from phase_cnt=4
  - tweak_out_1=8'h55 while phase_cnt 0..3, then 0
- Handover: n_drive=8'h01 -> 8'h00 and p_drive=8'hFF -> 8'hFE on the same cycle -> output sequence n_out 01,00,00 and p_out FF,FF,FE; no cycle has p_out[0]=0 and n_out[0]=1.
- Conflict: p_drive=8'hFE, n_drive=8'h01 for 3 cycles -> leg 0 stays off, fault=1, fault_cnt=3. Then fault_clr with no conflict -> fault=0, fault_cnt stays 3.
- pwm held constant for 300 cycles -> phase_cnt saturates at 255 without wrap; a sense=1 lane stays active throughout.
- en deasserted mid-phase -> next cycle p_out=FF, n_out=00, all tweak_out=0. Re-enable -> outputs resume with no counter reset.

Source files
------------

// File: rtl/pat_drive_pkg.sv
// Shared constants for the pattern-buffer drive path.
package pat_drive_pkg;

  localparam int DRIVE_WIDTH = 8;
  localparam int NUM_TWEAK   = 8;
  localparam int DELAY_WIDTH = 8;

  // Safe state: high-side gates are active-low, low-side gates active-high.
  localparam logic [DRIVE_WIDTH-1:0] P_OFF = '1;
  localparam logic [DRIVE_WIDTH-1:0] N_OFF = '0;

  localparam logic [7:0] FAULT_CNT_MAX = 8'hFF;

endpackage

// File: rtl/drive_leg_guard.sv
// One output leg: shoot-through veto plus break-before-make on the
// registered gate pair. A side may only turn on once the opposite side's
// registered gate is observed off, which forces an all-off cycle on handover.
module drive_leg_guard (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic p_drv,     // active-low high-side request
  input  logic n_drv,     // active-high low-side request
  output logic p_out,
  output logic n_out,
  output logic conflict
);

  logic p_on_ok;
  logic n_on_ok;

  assign conflict = ~p_drv & n_drv;
  assign p_on_ok  = ~conflict & ~n_out;
  assign n_on_ok  = ~conflict & p_out;

  // Registered gates; anything not explicitly allowed falls to off.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_out <= 1'b1;
      n_out <= 1'b0;
    end else begin
      p_out <= (en & p_on_ok) ? p_drv : 1'b1;
      n_out <= (en & n_on_ok) ? n_drv : 1'b0;
    end
  end

endmodule

// File: rtl/drive_stage.sv
// Final registered gate stage after the pattern buffer: time-gated tweak
// lanes, per-leg shoot-through/break-before-make guard, sticky fault.
module drive_stage
  import pat_drive_pkg::*;
#(
  parameter int buffer_width = DRIVE_WIDTH,
  parameter int cnt_width    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pwm,
  input  logic                    en,
  input  logic                    fault_clr,
  input  logic [buffer_width-1:0] p_drive,
  input  logic [buffer_width-1:0] n_drive,
  input  logic [7:0]              tweak_delay,
  input  logic [7:0]              tweak_sense,
  input  logic [buffer_width-1:0] tweak_drive_0,
  input  logic [buffer_width-1:0] tweak_drive_1,
  input  logic [buffer_width-1:0] tweak_drive_2,
  input  logic [buffer_width-1:0] tweak_drive_3,
  input  logic [buffer_width-1:0] tweak_drive_4,
  input  logic [buffer_width-1:0] tweak_drive_5,
  input  logic [buffer_width-1:0] tweak_drive_6,
  input  logic [buffer_width-1:0] tweak_drive_7,
  output logic [buffer_width-1:0] p_out,
  output logic [buffer_width-1:0] n_out,
  output logic [buffer_width-1:0] tweak_out_0,
  output logic [buffer_width-1:0] tweak_out_1,
  output logic [buffer_width-1:0] tweak_out_2,
  output logic [buffer_width-1:0] tweak_out_3,
  output logic [buffer_width-1:0] tweak_out_4,
  output logic [buffer_width-1:0] tweak_out_5,
  output logic [buffer_width-1:0] tweak_out_6,
  output logic [buffer_width-1:0] tweak_out_7,
  output logic                    fault,
  output logic [7:0]              fault_cnt
);

  logic                                  pwm_prev;
  logic                                  pwm_edge;
  logic [cnt_width-1:0]                  phase_cnt;
  logic [cnt_width-1:0]                  delay_ext;
  logic [NUM_TWEAK-1:0]                  active;
  logic [NUM_TWEAK-1:0][buffer_width-1:0] tweak_in;
  logic [NUM_TWEAK-1:0][buffer_width-1:0] tweak_q;
  logic [buffer_width-1:0]               conflict;
  logic                                  any_conf;

  assign pwm_edge  = pwm ^ pwm_prev;
  assign delay_ext = cnt_width'(tweak_delay);
  assign any_conf  = |conflict;

  assign tweak_in = {tweak_drive_7, tweak_drive_6, tweak_drive_5, tweak_drive_4,
                     tweak_drive_3, tweak_drive_2, tweak_drive_1, tweak_drive_0};

  assign tweak_out_0 = tweak_q[0];
  assign tweak_out_1 = tweak_q[1];
  assign tweak_out_2 = tweak_q[2];
  assign tweak_out_3 = tweak_q[3];
  assign tweak_out_4 = tweak_q[4];
  assign tweak_out_5 = tweak_q[5];
  assign tweak_out_6 = tweak_q[6];
  assign tweak_out_7 = tweak_q[7];

  // Phase timer: restarts on either pwm edge, saturates instead of wrapping
  // so late lanes stay on through long phases. Independent of en.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_prev  <= 1'b0;
      phase_cnt <= '0;
    end else begin
      pwm_prev <= pwm;
      if (pwm_edge)
        phase_cnt <= '0;
      else if (phase_cnt != '1)
        phase_cnt <= phase_cnt + 1'b1;
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_TWEAK; k++) begin : g_lane
      // sense=1: late lane (on from tweak_delay); sense=0: early lane.
      assign active[k] = tweak_sense[k] ? (phase_cnt >= delay_ext)
                                        : (phase_cnt <  delay_ext);

      // Registered tweak gate, forced off when disabled or outside window.
      always_ff @(posedge clk) begin
        if (reset)
          tweak_q[k] <= '0;
        else
          tweak_q[k] <= (en && active[k]) ? tweak_in[k] : '0;
      end
    end

    for (k = 0; k < buffer_width; k++) begin : g_leg
      drive_leg_guard u_leg (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .p_drv    (p_drive[k]),
        .n_drv    (n_drive[k]),
        .p_out    (p_out[k]),
        .n_out    (n_out[k]),
        .conflict (conflict[k])
      );
    end
  endgenerate

  // Sticky fault (new conflict beats clear) and saturating conflict counter.
  // Conflicts only count while enabled; the counter clears on reset alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault     <= 1'b0;
      fault_cnt <= '0;
    end else begin
      if (any_conf && en)
        fault <= 1'b1;
      else if (fault_clr)
        fault <= 1'b0;
      if (any_conf && en && fault_cnt != FAULT_CNT_MAX)
        fault_cnt <= fault_cnt + 8'd1;
    end
  end

endmodule
